// File: rtl/tile_pingpong_ctrl_if.sv
// Handshake bundle for tile_pingpong_ctrl: run control, loader fill port,
// compute consume port and status flags.
interface tile_pingpong_ctrl_if #(
  parameter int ADDR_W     = 10,
  parameter int TILE_CNT_W = 16
);
  logic                  start;
  logic [TILE_CNT_W-1:0] num_tiles;
  logic [ADDR_W:0]       tile_words;
  logic                  fill_req;
  logic                  fill_bank;
  logic                  fill_we;
  logic [ADDR_W-1:0]     fill_addr;
  logic                  consume_req;
  logic                  consume_bank;
  logic                  consume_done;
  logic [1:0]            bank_full;
  logic                  busy;
  logic                  done;

  modport slave (
    input  start, num_tiles, tile_words, fill_we, consume_done,
    output fill_req, fill_bank, fill_addr, consume_req, consume_bank,
           bank_full, busy, done
  );

  modport master (
    output start, num_tiles, tile_words, fill_we, consume_done,
    input  fill_req, fill_bank, fill_addr, consume_req, consume_bank,
           bank_full, busy, done
  );
endinterface

// File: rtl/tile_pingpong_ctrl.sv
// Ping-pong (double-buffer) bank controller: a loader fills one bank while
// compute consumes the other, alternating strictly from bank 0 each run.
module tile_pingpong_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int TILE_CNT_W = 16
) (
  input logic                 clk,
  input logic                 rstn,
  tile_pingpong_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [ADDR_W:0]       DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]       ONE_W = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]     ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [TILE_CNT_W-1:0] ONE_T = {{(TILE_CNT_W-1){1'b0}}, 1'b1};

  state_t                state, nstate;
  logic [1:0]            full, nfull;
  logic                  fptr, nfptr;
  logic                  cptr, ncptr;
  logic [ADDR_W-1:0]     wcnt, nwcnt;
  logic [ADDR_W-1:0]     last_word, nlast_word, start_last;
  logic [TILE_CNT_W-1:0] ntiles, nntiles;
  logic [TILE_CNT_W-1:0] filled, nfilled;
  logic [TILE_CNT_W-1:0] consumed, nconsumed;
  logic                  fill_acc, cons_acc;

  // Last word index of a tile: 0 and 1 words both give index 0, oversize
  // requests saturate at the bank depth.
  always_comb begin
    start_last = '0;
    if (bus.tile_words > DEPTH) begin
      start_last = '1;
    end else if (bus.tile_words > ONE_W) begin
      start_last = bus.tile_words[ADDR_W-1:0] - ONE_A;
    end
  end

  always_comb begin
    nstate     = state;
    nfull      = full;
    nfptr      = fptr;
    ncptr      = cptr;
    nwcnt      = wcnt;
    nlast_word = last_word;
    nntiles    = ntiles;
    nfilled    = filled;
    nconsumed  = consumed;
    fill_acc   = bus.fill_req & bus.fill_we;
    cons_acc   = bus.consume_req & bus.consume_done;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          nstate     = RUN;
          nntiles    = bus.num_tiles;
          nlast_word = start_last;
          nfull      = '0;
          nfptr      = 1'b0;
          ncptr      = 1'b0;
          nwcnt      = '0;
          nfilled    = '0;
          nconsumed  = '0;
        end
      end
      RUN: begin
        if (consumed == ntiles) begin
          nstate = DONE;
        end
        // Fill and consume always target different banks, so both apply.
        if (fill_acc) begin
          if (wcnt == last_word) begin
            nfull[fptr] = 1'b1;
            nwcnt       = '0;
            nfilled     = filled + ONE_T;
            nfptr       = ~fptr;
          end else begin
            nwcnt = wcnt + ONE_A;
          end
        end
        if (cons_acc) begin
          nfull[cptr] = 1'b0;
          nconsumed   = consumed + ONE_T;
          ncptr       = ~cptr;
        end
      end
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so they describe the
  // state held during the following cycle with no input-to-output path.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      full             <= '0;
      fptr             <= 1'b0;
      cptr             <= 1'b0;
      wcnt             <= '0;
      last_word        <= '0;
      ntiles           <= '0;
      filled           <= '0;
      consumed         <= '0;
      bus.fill_req     <= 1'b0;
      bus.fill_bank    <= 1'b0;
      bus.fill_addr    <= '0;
      bus.consume_req  <= 1'b0;
      bus.consume_bank <= 1'b0;
      bus.bank_full    <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
    end else begin
      state            <= nstate;
      full             <= nfull;
      fptr             <= nfptr;
      cptr             <= ncptr;
      wcnt             <= nwcnt;
      last_word        <= nlast_word;
      ntiles           <= nntiles;
      filled           <= nfilled;
      consumed         <= nconsumed;
      bus.fill_req     <= (nstate == RUN) && !nfull[nfptr] && (nfilled < nntiles);
      bus.fill_bank    <= nfptr;
      bus.fill_addr    <= nwcnt;
      bus.consume_req  <= (nstate == RUN) && nfull[ncptr];
      bus.consume_bank <= ncptr;
      bus.bank_full    <= nfull;
      bus.busy         <= (nstate != IDLE);
      bus.done         <= (nstate == DONE);
    end
  end

endmodule
